if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the RISC-V pipeline. It owns the program counter, drives the word address into the combinational instruction memory, and captures the returned instruction into the IF/ID pipeline register for decode. The hazard unit controls it through stall and flush, and the EX stage supplies branch and jump redirects. A misaligned redirect target parks the stage in a trap state until it receives an aligned redirect.

## Interface
Parameters:
- PC_WIDTH, 32, program-counter and address width.
- INST_WIDTH, 32, instruction width.
- RESET_PC, 32'h0000_0000, first fetch address; must be word-aligned.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- stall_i  in  1  hold PC and IF/ID (load-use hazard).
- flush_i  in  1  redirect taken; squash IF/ID and load redirect_pc_i.
- redirect_pc_i  in  PC_WIDTH  branch/jump target from EX.
- imem_pc_o  out  PC_WIDTH  fetch address to instruction memory (= PC register).
- imem_inst_i  in  INST_WIDTH  instruction returned combinationally for imem_pc_o.
- if_id_pc_o  out  PC_WIDTH  PC of the instruction held in IF/ID.
- if_id_pc4_o  out  PC_WIDTH  that PC + 4 (link value).
- if_id_inst_o  out  INST_WIDTH  instruction held in IF/ID.
- if_id_valid_o  out  1  IF/ID holds a real instruction.
- trap_o  out  1  stage is in TRAP (misaligned fetch target).
- trap_pc_o  out  PC_WIDTH  offending target while trap_o = 1.
- fetch_count_o  out  32  count of valid instructions delivered to IF/ID.

## Operation
- State machine: RUN and TRAP; reset state RUN.
- Per-edge priority: reset > flush_i > stall_i > normal advance.
- RUN, flush_i = 1, target aligned (redirect_pc_i[1:0] = 0):
  - PC loads the target.
  - IF/ID becomes a bubble: valid 0, inst NOP 32'h0000_0013, pc and pc4 0.
  - Stay in RUN.
- RUN, flush_i = 1, target misaligned:
  - PC loads the target and IF/ID becomes a bubble.
  - Go to TRAP; trap_pc_o equals the target.
- RUN, stall_i = 1 (no flush): PC, IF/ID and fetch_count_o all hold.
- RUN, normal advance:
  - PC advances to PC + 4.
  - IF/ID loads {PC, PC + 4, imem_inst_i, valid 1}.
  - fetch_count_o increments by 1.
- TRAP:
  - PC holds, and IF/ID is a bubble on every non-stalled edge.
  - trap_o = 1 and fetch_count_o holds.
  - flush_i with an aligned target returns to RUN, applying the RUN flush rule.
  - flush_i with a misaligned target stays in TRAP and updates PC and trap_pc_o.
- Arithmetic wraps modulo 2^PC_WIDTH: 0xFFFF_FFFC + 4 = 0. fetch_count_o wraps from 0xFFFF_FFFF to 0.
- Stage outputs are never X/Z after reset. A high-impedance imem_inst_i is not checked here, because PC is always aligned in RUN.

## Timing
- Reset values:
  - imem_pc_o = RESET_PC.
  - if_id_pc_o = 0 and if_id_pc4_o = 0.
  - if_id_inst_o = 32'h0000_0013 and if_id_valid_o = 0.
  - trap_o = 0, trap_pc_o = 0, fetch_count_o = 0.
- rst_n low at an edge resets everything, even mid-stall, mid-flush or in TRAP. The first fetch after rst_n rises is RESET_PC.
- Fetch latency is 1 cycle: imem_pc_o = A in cycle N gives IF/ID holding A in cycle N+1.
- Redirect latency: flush_i at edge N puts the target on imem_pc_o after N. The target instruction is in IF/ID after edge N+1 if that cycle is unstalled, giving exactly one bubble.
- stall_i and flush_i together: flush wins, so no stale instruction survives.
- imem_pc_o is a direct register output, with no combinational path from any input.

## Structure
- Shared package riscv_pkg holds:
  - XLEN = 32.
  - NOP_INST = 32'h0000_0013.
  - The fetch-state enum {FS_RUN, FS_TRAP}.
- One sub-module, if_id_reg, is the IF/ID pipeline register with load, hold and bubble controls. The PC, FSM and counter live in if_stage.

## Test plan
- Reset then 4 free-running cycles:
  - imem_pc_o goes 0, 4, 8, 0xC.
  - IF/ID pc goes 0, 4, 8 with matching instructions; fetch_count_o = 3 after the third load.
- Stall for 2 cycles at PC 8: imem_pc_o stays 8, IF/ID stays (4, inst@4), and the count holds; release resumes at 8.
- Flush to 0x100 while stall_i = 1: next imem_pc_o = 0x100, IF/ID valid 0 with NOP, then inst@0x100 with valid 1.
- Flush to 0x102:
  - trap_o = 1 and trap_pc_o = 0x102; IF/ID stays a bubble and the count is frozen for 5 cycles.
  - A flush to 0x200 clears trap_o, then fetches 0x200.
- PC at 0xFFFF_FFFC advancing: next imem_pc_o = 0. Also pulse rst_n low in TRAP: all outputs return to their reset values on that edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline constants and the fetch-stage state encoding.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic {
        FS_RUN  = 1'b0,
        FS_TRAP = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bundle: hazard/redirect controls, instruction memory port, IF/ID outputs.
// master = the fetch stage, slave = the surrounding pipeline and memory.
interface if_stage_if
    import riscv_pkg::*;
#(
    parameter int PC_WIDTH   = XLEN,
    parameter int INST_WIDTH = XLEN
);
    logic                  stall_i;
    logic                  flush_i;
    logic [PC_WIDTH-1:0]   redirect_pc_i;
    logic [PC_WIDTH-1:0]   imem_pc_o;
    logic [INST_WIDTH-1:0] imem_inst_i;
    logic [PC_WIDTH-1:0]   if_id_pc_o;
    logic [PC_WIDTH-1:0]   if_id_pc4_o;
    logic [INST_WIDTH-1:0] if_id_inst_o;
    logic                  if_id_valid_o;
    logic                  trap_o;
    logic [PC_WIDTH-1:0]   trap_pc_o;
    logic [31:0]           fetch_count_o;

    modport master (
        input  stall_i, flush_i, redirect_pc_i, imem_inst_i,
        output imem_pc_o, if_id_pc_o, if_id_pc4_o, if_id_inst_o, if_id_valid_o,
               trap_o, trap_pc_o, fetch_count_o
    );

    modport slave (
        output stall_i, flush_i, redirect_pc_i, imem_inst_i,
        input  imem_pc_o, if_id_pc_o, if_id_pc4_o, if_id_inst_o, if_id_valid_o,
               trap_o, trap_pc_o, fetch_count_o
    );
endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: bubble beats load, otherwise holds; 1-cycle capture.
// No backpressure of its own: the caller simply withholds load to stall.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter int PC_WIDTH   = XLEN,
    parameter int INST_WIDTH = XLEN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  bubble,
    input  logic [PC_WIDTH-1:0]   pc_d,
    input  logic [PC_WIDTH-1:0]   pc4_d,
    input  logic [INST_WIDTH-1:0] inst_d,
    output logic [PC_WIDTH-1:0]   pc_q,
    output logic [PC_WIDTH-1:0]   pc4_q,
    output logic [INST_WIDTH-1:0] inst_q,
    output logic                  valid_q
);

    always_ff @(posedge clk) begin
        if (!rst_n || bubble) begin
            pc_q    <= '0;
            pc4_q   <= '0;
            inst_q  <= INST_WIDTH'(NOP_INST);
            valid_q <= 1'b0;
        end else if (load) begin
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            inst_q  <= inst_d;
            valid_q <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register, RUN/TRAP FSM, fetch counter; 1-cycle fetch latency.
// stall_i holds PC, IF/ID and counter; flush_i overrides stall and redirects.
module if_stage
    import riscv_pkg::*;
#(
    parameter int                  PC_WIDTH   = 32,
    parameter int                  INST_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
    input logic      clk,
    input logic      rst_n,
    if_stage_if.master bus
);

    fetch_state_t        state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] pc4;
    logic [PC_WIDTH-1:0] trap_pc_q, trap_pc_d;
    logic [31:0]         cnt_q, cnt_d;
    logic                ld;
    logic                bub;
    logic                misaligned;

    assign pc4        = pc_q + PC_WIDTH'(4);
    assign misaligned = (bus.redirect_pc_i[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FS_RUN;
            pc_q      <= RESET_PC;
            trap_pc_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            trap_pc_q <= trap_pc_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        trap_pc_d = trap_pc_q;
        cnt_d     = cnt_q;
        ld        = 1'b0;
        bub       = 1'b0;
        if (bus.flush_i) begin
            pc_d = bus.redirect_pc_i;
            bub  = 1'b1;
            if (misaligned) begin
                state_d   = FS_TRAP;
                trap_pc_d = bus.redirect_pc_i;
            end else begin
                state_d   = FS_RUN;
                trap_pc_d = '0;
            end
        end else if (!bus.stall_i) begin
            unique case (state_q)
                FS_RUN: begin
                    pc_d  = pc4;
                    ld    = 1'b1;
                    cnt_d = cnt_q + 32'd1;
                end
                // Parked on a bad target: keep squashing until a good redirect.
                FS_TRAP: bub = 1'b1;
                default: state_d = FS_RUN;
            endcase
        end
    end

    if_id_reg #(
        .PC_WIDTH   (PC_WIDTH),
        .INST_WIDTH (INST_WIDTH)
    ) u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (ld),
        .bubble  (bub),
        .pc_d    (pc_q),
        .pc4_d   (pc4),
        .inst_d  (bus.imem_inst_i),
        .pc_q    (bus.if_id_pc_o),
        .pc4_q   (bus.if_id_pc4_o),
        .inst_q  (bus.if_id_inst_o),
        .valid_q (bus.if_id_valid_o)
    );

    assign bus.imem_pc_o     = pc_q;
    assign bus.trap_o        = (state_q == FS_TRAP);
    assign bus.trap_pc_o     = trap_pc_q;
    assign bus.fetch_count_o = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    if_stage_if #(.PC_WIDTH(32), .INST_WIDTH(32)) bus ();

    if_stage #(.PC_WIDTH(32), .INST_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    // Instruction memory: combinational, content is a function of address.
    assign bus.imem_inst_i = inst_of(bus.imem_pc_o);

    // Reference model state.
    logic [31:0] m_pc, m_ipc, m_ipc4, m_inst, m_tpc, m_cnt;
    logic        m_v, m_trap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic st, input logic fl, input logic [31:0] rpc);
        if (!r) begin
            m_pc = 32'h0; m_ipc = 0; m_ipc4 = 0; m_inst = NOP_INST; m_v = 0;
            m_trap = 0; m_tpc = 0; m_cnt = 0;
        end else if (fl) begin
            m_ipc = 0; m_ipc4 = 0; m_inst = NOP_INST; m_v = 0;
            m_pc = rpc;
            m_trap = (rpc % 4) != 0;
            m_tpc  = m_trap ? rpc : 32'h0;
        end else if (st) begin
            // everything holds
        end else if (!m_trap) begin
            m_ipc = m_pc; m_ipc4 = m_pc + 4; m_inst = inst_of(m_pc); m_v = 1;
            m_cnt = m_cnt + 1;
            m_pc  = m_pc + 4;
        end else begin
            m_ipc = 0; m_ipc4 = 0; m_inst = NOP_INST; m_v = 0;
        end
    endtask

    task automatic check_all();
        chk("imem_pc", bus.imem_pc_o, m_pc);
        chk("if_id_pc", bus.if_id_pc_o, m_ipc);
        chk("if_id_pc4", bus.if_id_pc4_o, m_ipc4);
        chk("if_id_inst", bus.if_id_inst_o, m_inst);
        chk("if_id_valid", {31'b0, bus.if_id_valid_o}, {31'b0, m_v});
        chk("trap", {31'b0, bus.trap_o}, {31'b0, m_trap});
        if (m_trap) chk("trap_pc", bus.trap_pc_o, m_tpc);
        chk("fetch_count", bus.fetch_count_o, m_cnt);
    endtask

    // Apply inputs for one cycle, clock it, then compare against the model.
    task automatic step(input logic r, input logic st, input logic fl, input logic [31:0] rpc);
        rst_n             = r;
        bus.stall_i       = st;
        bus.flush_i       = fl;
        bus.redirect_pc_i = rpc;
        @(posedge clk);
        model_edge(r, st, fl, rpc);
        #1;
        check_all();
    endtask

    initial begin
        logic        r, st, fl;
        logic [31:0] rpc;
        rst_n = 1'b0; bus.stall_i = 1'b0; bus.flush_i = 1'b0; bus.redirect_pc_i = '0;
        #1;

        // Reset
        step(0, 0, 0, 0);
        step(0, 1, 1, 32'h44);
        chk("rst_imem_pc", bus.imem_pc_o, 32'h0);
        chk("rst_inst_nop", bus.if_id_inst_o, 32'h0000_0013);
        chk("rst_trap_pc", bus.trap_pc_o, 32'h0);

        // Free running
        step(1, 0, 0, 0);
        chk("run_pc1", bus.imem_pc_o, 32'h4);
        chk("run_ifid0", bus.if_id_pc_o, 32'h0);
        step(1, 0, 0, 0);
        chk("run_pc2", bus.imem_pc_o, 32'h8);
        chk("run_ifid4_inst", bus.if_id_inst_o, inst_of(32'h4));

        // Stall two cycles at PC 8
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("stall_pc", bus.imem_pc_o, 32'h8);
        chk("stall_ifid", bus.if_id_pc_o, 32'h4);
        chk("stall_cnt", bus.fetch_count_o, 32'd2);
        step(1, 0, 0, 0);
        chk("resume_ifid8", bus.if_id_pc_o, 32'h8);
        chk("resume_cnt", bus.fetch_count_o, 32'd3);
        chk("resume_pc", bus.imem_pc_o, 32'hC);

        // Flush while stalled
        step(1, 1, 1, 32'h100);
        chk("flush_pc", bus.imem_pc_o, 32'h100);
        chk("flush_bubble_v", {31'b0, bus.if_id_valid_o}, 32'h0);
        step(1, 0, 0, 0);
        chk("flush_tgt_inst", bus.if_id_inst_o, inst_of(32'h100));
        chk("flush_tgt_v", {31'b0, bus.if_id_valid_o}, 32'h1);

        // Misaligned redirect -> trap, frozen for 5 cycles
        step(1, 0, 1, 32'h102);
        chk("trap_on", {31'b0, bus.trap_o}, 32'h1);
        chk("trap_pc_val", bus.trap_pc_o, 32'h102);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        chk("trap_cnt_frozen", bus.fetch_count_o, 32'd4);
        chk("trap_bubble_inst", bus.if_id_inst_o, 32'h0000_0013);
        step(1, 0, 1, 32'h200);
        chk("trap_off", {31'b0, bus.trap_o}, 32'h0);
        step(1, 0, 0, 0);
        chk("trap_exit_fetch", bus.if_id_pc_o, 32'h200);

        // PC wrap
        step(1, 0, 1, 32'hFFFF_FFFC);
        step(1, 0, 0, 0);
        chk("wrap_pc", bus.imem_pc_o, 32'h0);
        chk("wrap_pc4", bus.if_id_pc4_o, 32'h0);
        chk("wrap_ifid", bus.if_id_pc_o, 32'hFFFF_FFFC);

        // Reset pulse while trapped
        step(1, 0, 1, 32'h3);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        chk("rst_in_trap_trap", {31'b0, bus.trap_o}, 32'h0);
        chk("rst_in_trap_cnt", bus.fetch_count_o, 32'h0);
        chk("rst_in_trap_pc", bus.imem_pc_o, 32'h0);
        step(1, 0, 0, 0);
        chk("post_rst_fetch0", bus.if_id_pc_o, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            r   = ($urandom_range(0, 79) != 0);
            st  = ($urandom_range(0, 4) == 0);
            fl  = ($urandom_range(0, 7) == 0);
            rpc = $urandom();
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            else if (rpc[1:0] == 2'b00) rpc[0] = 1'b1;
            if ($urandom_range(0, 15) == 0) rpc = 32'hFFFF_FFF8;
            step(r, st, fl, rpc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
